// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch sequencer: IDLE -> FETCH -> ISSUE -> ADVANCE, with HALT and redirect handling.
// Optional fetch watchdog enabled by defining FETCH_WATCHDOG_EN (adds sticky FAULT state).
module fetch_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             run_i,
    input  logic [31:0]      pc_i,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_offset,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic             pc_load,
    output logic             pc_src,
    output logic [31:0]      pc_target,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StIssue   = 3'd2;
    localparam logic [2:0] StAdvance = 3'd3;
    localparam logic [2:0] StHalt    = 3'd4;
    localparam logic [2:0] StFault   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [31:0]      instr_q, instr_pc_q, pc_target_q;
    logic             pc_src_q;
    logic [CNT_W-1:0] retired_q;
    logic             handshake;
    logic             wd_expire;

    assign handshake = (state_q == StIssue) && instr_ready;

`ifdef FETCH_WATCHDOG_EN
    localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);
    logic [7:0] wait_q;

    // Ack in the expiring cycle still wins over the timeout.
    assign wd_expire = (state_q == StFetch) && !imem_ack && (wait_q == WdLast);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wait_q <= 8'd0;
        end else if (state_q != StFetch) begin
            wait_q <= 8'd0;
        end else if (!imem_ack) begin
            wait_q <= wait_q + 8'd1;
        end
    end

    assign fault = (state_q == StFault);
`else
    assign wd_expire = 1'b0;
    assign fault     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (run_i) state_d = StFetch;
            StFetch: begin
                if (imem_ack)       state_d = StIssue;
                else if (wd_expire) state_d = StFault;
            end
            StIssue:   if (instr_ready) state_d = halt_i ? StHalt : StAdvance;
            StAdvance: state_d = run_i ? StFetch : StIdle;
            StHalt:    if (resume_i) state_d = StAdvance;
            StFault:   state_d = StFault;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= StIdle;
            instr_q     <= 32'd0;
            instr_pc_q  <= 32'd0;
            pc_src_q    <= 1'b0;
            pc_target_q <= 32'd0;
            retired_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StFetch) && imem_ack) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc_i;
            end
            if (handshake) begin
                retired_q <= retired_q + 1'b1;
                // Halt suppresses any redirect for the same instruction.
                if (!halt_i) begin
                    pc_src_q    <= redirect_valid;
                    pc_target_q <= redirect_valid ? redirect_offset : 32'd0;
                end
            end
            if (state_q == StAdvance || state_q == StHalt) begin
                pc_src_q    <= 1'b0;
                pc_target_q <= 32'd0;
            end
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign instr_valid = (state_q == StIssue);
    assign pc_load     = (state_q == StAdvance);
    assign halted      = (state_q == StHalt);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_src      = pc_src_q;
    assign pc_target   = pc_target_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; watchdog scenario built when FETCH_WATCHDOG_EN is set.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        run_i = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_offset = 32'd0;
    logic        halt_i = 1'b0;
    logic        resume_i = 1'b0;
    logic        pc_load;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        halted;
    logic        fault;
    logic [31:0] retired_cnt;

    int checks = 0;
    int failures = 0;

    fetch_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .areset(areset), .run_i(run_i), .pc_i(pc_i),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .redirect_valid(redirect_valid),
        .redirect_offset(redirect_offset), .halt_i(halt_i), .resume_i(resume_i),
        .pc_load(pc_load), .pc_src(pc_src), .pc_target(pc_target), .halted(halted),
        .fault(fault), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        run_i = 1'b0; pc_i = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_offset = 32'd0;
        halt_i = 1'b0; resume_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset = 1'b0;
        step();
        step();
        areset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        run_i = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1) begin
            failures++; $display("FAIL reset_pre_fetch imem_req=%b exp=1", imem_req);
        end
        #2 areset = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, pc_load, pc_src, halted, fault} !== 6'd0 ||
            instr !== 32'd0 || instr_pc !== 32'd0 || pc_target !== 32'd0 ||
            retired_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_async strobes=%b instr=%h pc=%h tgt=%h cnt=%0d exp all 0",
                     {imem_req, instr_valid, pc_load, pc_src, halted, fault}, instr, instr_pc,
                     pc_target, retired_cnt);
        end
        step();
        step();
        areset = 1'b1;
        run_i = 1'b0;
        step();
        checks++;
        if (imem_req !== 1'b0 || retired_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_idle imem_req=%b cnt=%0d exp 0/0", imem_req, retired_cnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_i = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0013; pc_i = 32'd0;
        instr_ready = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL basic_fetch req=%b valid=%b exp 1/0", imem_req, instr_valid);
        end
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'd0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_issue valid=%b instr=%h pc=%h req=%b exp 1/13/0/0",
                     instr_valid, instr, instr_pc, imem_req);
        end
        step();
        checks++;
        if (pc_load !== 1'b1 || pc_src !== 1'b0 || instr_valid !== 1'b0 || retired_cnt !== 32'd1) begin
            failures++;
            $display("FAIL basic_advance load=%b src=%b valid=%b cnt=%0d exp 1/0/0/1",
                     pc_load, pc_src, instr_valid, retired_cnt);
        end
        pc_i = 32'd4; imem_rdata = 32'h0040_0093;
        step();
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h0040_0093 || instr_pc !== 32'd4) begin
            failures++;
            $display("FAIL basic_second_issue valid=%b instr=%h pc=%h exp 1/00400093/4",
                     instr_valid, instr, instr_pc);
        end
        step();
        checks++;
        if (pc_load !== 1'b1 || retired_cnt !== 32'd2) begin
            failures++; $display("FAIL basic_second_adv load=%b cnt=%0d exp 1/2", pc_load, retired_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        run_i = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0063; pc_i = 32'h20;
        step();
        step();
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_offset = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0; redirect_offset = 32'd0; instr_ready = 1'b0; imem_ack = 1'b0;
        checks++;
        if (pc_load !== 1'b1 || pc_src !== 1'b1 || pc_target !== 32'hFFFF_FFF8) begin
            failures++;
            $display("FAIL redirect_advance load=%b src=%b tgt=%h exp 1/1/fffffff8",
                     pc_load, pc_src, pc_target);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || pc_load !== 1'b0 || pc_src !== 1'b0 || pc_target !== 32'd0) begin
            failures++;
            $display("FAIL redirect_refetch req=%b load=%b src=%b tgt=%h exp 1/0/0/0",
                     imem_req, pc_load, pc_src, pc_target);
        end
    endtask

    task automatic test_halt();
        do_reset();
        run_i = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0010_0073;
        step();
        step();
        instr_ready = 1'b1; halt_i = 1'b1; redirect_valid = 1'b1; redirect_offset = 32'h40;
        step();
        instr_ready = 1'b0; halt_i = 1'b0; redirect_valid = 1'b0; run_i = 1'b0;
        checks++;
        if (halted !== 1'b1 || pc_load !== 1'b0 || pc_src !== 1'b0 || retired_cnt !== 32'd1) begin
            failures++;
            $display("FAIL halt_enter halted=%b load=%b src=%b cnt=%0d exp 1/0/0/1",
                     halted, pc_load, pc_src, retired_cnt);
        end
        run_i = 1'b1;
        step();
        step();
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || pc_load !== 1'b0) begin
            failures++;
            $display("FAIL halt_hold halted=%b req=%b load=%b exp 1/0/0", halted, imem_req, pc_load);
        end
        resume_i = 1'b1;
        step();
        resume_i = 1'b0;
        checks++;
        if (pc_load !== 1'b1 || pc_src !== 1'b0 || pc_target !== 32'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_resume load=%b src=%b tgt=%h halted=%b exp 1/0/0/0",
                     pc_load, pc_src, pc_target, halted);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || pc_load !== 1'b0) begin
            failures++; $display("FAIL halt_refetch req=%b load=%b exp 1/0", imem_req, pc_load);
        end
    endtask

    task automatic test_stall();
        do_reset();
        run_i = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001; pc_i = 32'h100;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i % 2) == 0;
            imem_rdata = 32'h5555_0000 + i;
            pc_i = 32'h200 + 4 * i;
            redirect_valid = 1'b1; halt_i = 1'b1;
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'hAAAA_0001 || instr_pc !== 32'h100 ||
                pc_load !== 1'b0 || retired_cnt !== 32'd0) begin
                failures++;
                $display("FAIL stall_hold%0d valid=%b instr=%h pc=%h load=%b cnt=%0d exp 1/aaaa0001/100/0/0",
                         i, instr_valid, instr, instr_pc, pc_load, retired_cnt);
            end
        end
        redirect_valid = 1'b0; halt_i = 1'b0; instr_ready = 1'b1;
        step();
        checks++;
        if (pc_load !== 1'b1 || pc_src !== 1'b0 || retired_cnt !== 32'd1) begin
            failures++;
            $display("FAIL stall_release load=%b src=%b cnt=%0d exp 1/0/1", pc_load, pc_src, retired_cnt);
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        run_i = 1'b1; imem_ack = 1'b1;
        step();
        step();
        run_i = 1'b0;
        step();
        checks++;
        if (instr_valid !== 1'b1) begin
            failures++; $display("FAIL rundrop_issue valid=%b exp 1", instr_valid);
        end
        instr_ready = 1'b1;
        step();
        checks++;
        if (pc_load !== 1'b1) begin
            failures++; $display("FAIL rundrop_advance load=%b exp 1", pc_load);
        end
        step();
        checks++;
        if ({imem_req, instr_valid, pc_load, halted} !== 4'd0) begin
            failures++;
            $display("FAIL rundrop_idle strobes=%b exp 0000", {imem_req, instr_valid, pc_load, halted});
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        run_i = 1'b1;
        step();
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (imem_req !== 1'b1 || fault !== 1'b0) begin
            failures++; $display("FAIL wd_cycle16 req=%b fault=%b exp 1/0", imem_req, fault);
        end
        step();
`ifdef FETCH_WATCHDOG_EN
        checks++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || pc_load !== 1'b0) begin
            failures++;
            $display("FAIL wd_fault fault=%b req=%b load=%b exp 1/0/0", fault, imem_req, pc_load);
        end
        imem_ack = 1'b1; instr_ready = 1'b1; resume_i = 1'b1;
        step();
        step();
        checks++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL wd_sticky fault=%b req=%b valid=%b exp 1/0/0", fault, imem_req, instr_valid);
        end
        do_reset();
        checks++;
        if (fault !== 1'b0) begin
            failures++; $display("FAIL wd_reset fault=%b exp 0", fault);
        end
`else
        checks++;
        if (fault !== 1'b0 || imem_req !== 1'b1) begin
            failures++; $display("FAIL wd_absent fault=%b req=%b exp 0/1", fault, imem_req);
        end
        imem_ack = 1'b1;
        step();
        checks++;
        if (instr_valid !== 1'b1) begin
            failures++; $display("FAIL wd_late_ack valid=%b exp 1", instr_valid);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_redirect();
        test_halt();
        test_stall();
        test_run_drop();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Multi-cycle fetch sequencer for the RV32 core's program counter register.
- Drives the PC register's load/PCsrc/target inputs.
- Handshakes with instruction memory (req/ack) and hands fetched instructions to decode/execute (valid/ready).
- Applies branch/jump redirects and halt/resume, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TIMEOUT, 16, fetch watchdog limit in cycles; used only with FETCH_WATCHDOG_EN.

Ports:
- clk  input  1  clock, rising edge.
- areset  input  1  reset, asynchronous, active-low.
- run_i  input  1  level; core enabled.
- pc_i  input  32  current PC from PC register; also the imem address.
- imem_req  output  1  instruction memory request.
- imem_ack  input  1  memory data valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instruction presented to execute.
- instr_ready  input  1  execute accepts the instruction.
- instr  output  32  captured instruction.
- instr_pc  output  32  PC of captured instruction.
- redirect_valid  input  1  taken branch/jump for the accepted instruction; sampled only on the handshake.
- redirect_offset  input  32  signed PC-relative offset.
- halt_i  input  1  ebreak/ecall halt for the accepted instruction; sampled only on the handshake.
- resume_i  input  1  single-cycle pulse; leave HALT.
- pc_load  output  1  to PC register load.
- pc_src  output  1  to PC register PCsrc (1 = PC+target).
- pc_target  output  32  to PC register target.
- halted  output  1  in HALT state.
- fault  output  1  watchdog fault (0 without the macro).
- retired_cnt  output  CNT_W  handshakes completed.

Behaviour:
- Reset (areset=0, async): state=IDLE. Every output is 0: imem_req, instr_valid, instr, instr_pc, pc_load, pc_src, pc_target, halted, fault, retired_cnt.
- All outputs are registered or decoded from state only; none depends combinationally on inputs.
- IDLE: all strobes low.
  - run_i=1 -> FETCH.
- FETCH: imem_req=1; imem_ack is sampled only here (ack in any other state is ignored).
  - imem_ack=1 -> capture instr<=imem_rdata and instr_pc<=pc_i; -> ISSUE.
  - The ack may arrive in the first FETCH cycle, giving minimum 1-cycle memory latency.
- ISSUE: instr_valid=1; instr and instr_pc are held stable until the handshake.
  - Handshake (instr_ready=1), halt_i=1 -> HALT. PC is not updated; redirect is ignored (halt wins).
  - Handshake, halt_i=0 -> ADVANCE. Register pc_src<=redirect_valid; pc_target<=redirect_valid ? redirect_offset : 0.
  - retired_cnt increments on every handshake and wraps modulo 2^CNT_W.
- ADVANCE (exactly one cycle): pc_load=1 with the registered pc_src/pc_target, so the PC updates at the end of this cycle.
  - run_i=1 -> FETCH; run_i=0 -> IDLE.
  - pc_src/pc_target clear to 0 on exit.
- HALT: halted=1, pc_load=0.
  - resume_i=1 -> ADVANCE with pc_src=0 (PC+4).
  - run_i is ignored in HALT.
- pc_load is high only in ADVANCE. Best-case throughput is 1 instruction per 3 cycles (FETCH, ISSUE, ADVANCE).
- Nothing is latched outside the handshake; redirect_valid and halt_i outside it have no effect.
- run_i dropping during FETCH or ISSUE does not abort; the sequence completes, then IDLE is entered after ADVANCE.
- Reset mid-operation aborts immediately; any in-flight imem transaction is abandoned.

Optional Feature:
- Macro FETCH_WATCHDOG_EN.
- Defined: 8-bit wait counter, cleared on FETCH entry, increments each FETCH cycle without imem_ack.
  - Reaching TIMEOUT without ack -> FAULT state: fault=1, imem_req=0, pc_load=0.
  - FAULT is sticky; only areset exits.
  - An ack in the same cycle the count reaches TIMEOUT is accepted; ack wins.
- Undefined: no counter; FETCH waits indefinitely; fault is tied to 0.

Test Plan:
- Reset mid-FETCH, areset low for 2 cycles -> all outputs 0 asynchronously, state IDLE, retired_cnt=0.
- run_i=1, ack on first FETCH cycle, rdata=0x00000013, pc_i=0, ready=1 -> instr_valid 1 cycle with instr=0x13 and instr_pc=0; then pc_load=1, pc_src=0; retired_cnt=1; cycle repeats every 3 cycles.
- Handshake with redirect_valid=1, redirect_offset=-8 (0xFFFFFFF8) -> next cycle pc_load=1, pc_src=1, pc_target=0xFFFFFFF8; following cycle imem_req=1.
- Handshake with halt_i=1 and redirect_valid=1 -> halted=1, no pc_load pulse; resume_i pulse -> one pc_load with pc_src=0, then FETCH.
- ready held low 5 cycles with ack pulsing -> instr stable, no second capture, no pc_load until ready.
- With FETCH_WATCHDOG_EN, TIMEOUT=16, ack withheld -> fault=1 after 16 FETCH cycles, imem_req=0, fault remains until areset.
